multiexp_pnt_scl_stream: RTL and testbench
==========================================

# multiexp_pnt_scl_stream

Source side of the multiexp point/scalar stream. Holds NUM_IN point/scalar pairs in a local RAM loaded over a write stream. On a start command it replays them as the looping `{FP_TYPE, FE_TYPE}` stream that multiexp_core consumes:
- normal mode: NUM_IN × KEY_BITS beats;
- single-add mode: one beat.

It sits between the host/DMA load path and one multiexp core, with full AXI-stream backpressure.

## Interface
- FP_TYPE, none, point type (packed struct)
- FE_TYPE, none, scalar / field element type
- KEY_BITS, none, scalar bits; number of passes in normal mode
- CTL_BITS, 8, ctl width on both streams; must be ≥ max(1, $clog2(NUM_IN))
- NUM_IN, none, pairs held in RAM (≥1)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous reset, active-low
- i_wr_if  if_axi_stream.sink  dat=$bits(FP_TYPE)+$bits(FE_TYPE)  load stream:
  - dat = {point, scalar};
  - ctl[AW-1:0] = RAM index, where AW = max(1, $clog2(NUM_IN)).
- i_start  in  1  start pulse, sampled only while idle
- i_mode  in  1  sampled with i_start: 0 normal, 1 single-add
- o_pnt_scl_if  if_axi_stream.source  same dat width  output stream:
  - ctl[0] = latched mode; other ctl bits 0;
  - sop on the first beat of each pass;
  - eop on the last beat of each pass (index NUM_IN-1; every beat in single-add mode).
- o_busy  out  1  high from start acceptance until the final output handshake
- o_done  out  1  one-cycle pulse after the final handshake
- o_wr_err  out  1  sticky dropped-write flag (only with MULTIEXP_STREAM_WR_ERR_EN; tied 0 otherwise)

## Operation
- RAM: NUM_IN entries, 1-cycle registered read, not reset. Contents survive reset and runs.
- Write: a handshake on i_wr_if writes dat to the RAM at ctl[AW-1:0]. Indices ≥ NUM_IN are dropped silently.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - i_start=1 latches i_mode.
  - Clears the index counter (idx) and the pass counter (pass).
  - Sets o_busy and moves to RUN.
- RUN:
  - Issues a RAM read whenever the 2-entry output skid buffer has a free slot, including a slot freed in the same cycle.
  - After each read, idx increments.
  - At idx == NUM_IN-1, idx wraps to 0 and pass increments.
  - After the last read, moves to FLUSH. The last read is at idx NUM_IN-1 with pass KEY_BITS-1 in normal mode, or the single read of idx 0 in single-add mode.
- FLUSH:
  - Drains the buffer.
  - On the handshake of the final beat: clears o_busy, pulses o_done the next cycle, returns to IDLE.
- sop/eop/ctl are computed at read issue and travel with the data through the buffer.
- i_start while busy is ignored.
- Without MULTIEXP_STREAM_WR_ERR_EN, i_wr_if.rdy = ~o_busy: writes stall while busy.
- Write and start in the same idle cycle: the write commits at that edge and the first read occurs the following cycle, so the read sees the new data.
- NUM_IN=1: idx stays 0, and every beat has sop=eop=1.

## Timing
- Reset values:
  - o_pnt_scl_if: val=0, sop=0, eop=0, dat=0, ctl=0.
  - o_busy=0, o_done=0, o_wr_err=0.
  - i_wr_if.rdy=1; state IDLE; skid buffer empty.
- Start latency: i_start at cycle T → o_busy=1 at T+1, first RAM read at T+1, o_pnt_scl_if.val=1 at T+2.
- Throughput: with rdy held high, one beat per cycle with no bubbles, including across pass boundaries.
- Backpressure:
  - dat/ctl/sop/eop stay stable while val && !rdy.
  - val never drops without a handshake.
  - rdy may toggle arbitrarily, and the buffer covers the consumer's registered rdy.
- Beat count: total handshakes equal exactly NUM_IN×KEY_BITS (normal) or 1 (single-add).
- Reset mid-run: the next cycle is IDLE with the buffer flushed and val=0; no o_done is issued.

## Configuration
- MULTIEXP_STREAM_WR_ERR_EN defined:
  - i_wr_if.rdy is constant 1.
  - A write handshake while o_busy=1 is dropped, the RAM is unchanged, and o_wr_err is set.
  - o_wr_err clears only on accepted i_start or reset.
- Not defined: writes are backpressured while busy and o_wr_err is tied 0.

## Test plan
- Load NUM_IN=4 with scalars 1,2,3,4; start normal mode with KEY_BITS=3, rdy always 1 → 12 contiguous beats, scalar sequence 1,2,3,4 repeated 3×, sop at beats 0/4/8, eop at beats 3/7/11, o_done one cycle after beat 11.
- Same run with rdy random at 30% duty → identical 12-beat sequence, no beat lost or repeated, data stable during stalls.
- Single-add mode with entry 0 = {P0, 0x5} → one beat with ctl[0]=1, sop=eop=1, then o_done; entries 1..3 never appear.
- Write to idx 2 while busy:
  - without the macro, rdy stays 0 until o_done, then the write lands;
  - with the macro, the write is dropped, o_wr_err=1, and the next start clears it.
- Assert reset after beat 5 of 12 → val=0 next cycle, no o_done; a restart streams all 12 beats from idx 0 with the RAM data intact.
- NUM_IN=1, KEY_BITS=2 → 2 beats, each with sop=eop=1.

Source files
------------

// File: rtl/multiexp_pnt_scl_stream_if.sv
// AXI-stream style bundle shared by the point/scalar load path and the multiexp core feed.
interface if_axi_stream #(
    parameter int DAT_BITS = 8,
    parameter int CTL_BITS = 8
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport sink   (input val, sop, eop, dat, ctl, output rdy);
    modport source (output val, sop, eop, dat, ctl, input rdy);
endinterface

// File: rtl/multiexp_pnt_scl_stream.sv
// Holds NUM_IN point/scalar pairs and replays them as the looping multiexp_core input stream.
// Optional MULTIEXP_STREAM_WR_ERR_EN: writes never stall; writes while busy are dropped and flagged.
module multiexp_pnt_scl_stream #(
    parameter type FP_TYPE  = logic [15:0],
    parameter type FE_TYPE  = logic [7:0],
    parameter int  KEY_BITS = 8,
    parameter int  CTL_BITS = 8,
    parameter int  NUM_IN   = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    if_axi_stream.sink   i_wr_if,
    input  logic         i_start,
    input  logic         i_mode,
    if_axi_stream.source o_pnt_scl_if,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_wr_err
);
    localparam int DW = $bits(FP_TYPE) + $bits(FE_TYPE);
    localparam int AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_IN - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(KEY_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] mem [NUM_IN];
    logic [AW-1:0] idx;
    logic [PW-1:0] pass;
    logic          mode_r;
    logic          start_acc;
    logic          rd_en;
    logic          last_rd;
    logic          last_beat;

    logic [AW-1:0] wr_idx;
    logic          wr_in_range;
    logic          wr_en;

    // Two-entry skid buffer; each slot is also the RAM's registered read port.
    logic [DW-1:0] skid_dat_p1 [2];
    logic [1:0]    skid_sop_p1;
    logic [1:0]    skid_eop_p1;
    logic [1:0]    skid_mode_p1;
    logic [1:0]    skid_cnt;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          vld_p1;
    logic          out_fire;
    logic          skid_free;

    assign o_busy      = (state != IDLE);
    assign wr_idx      = i_wr_if.ctl[AW-1:0];
    assign wr_in_range = (32'(wr_idx) < NUM_IN);
    assign last_rd     = mode_r || ((idx == IDX_LAST) && (pass == PASS_LAST));

    assign vld_p1    = (skid_cnt != 2'd0);
    assign out_fire  = vld_p1 && o_pnt_scl_if.rdy;
    assign skid_free = (skid_cnt != 2'd2) || out_fire;

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        rd_en     = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_en = skid_free;
                if (skid_free && last_rd) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (out_fire && (skid_cnt == 2'd1)) begin
                    last_beat = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            pass     <= '0;
            mode_r   <= 1'b0;
            o_done   <= 1'b0;
            skid_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_done   <= last_beat;
            skid_cnt <= skid_cnt + 2'(rd_en) - 2'(out_fire);
            if (rd_en)    wr_ptr <= ~wr_ptr;
            if (out_fire) rd_ptr <= ~rd_ptr;
            if (start_acc) begin
                mode_r <= i_mode;
                idx    <= '0;
                pass   <= '0;
            end else if (rd_en) begin
                if (idx == IDX_LAST) begin
                    idx  <= '0;
                    pass <= pass + PW'(1);
                end else begin
                    idx <= idx + AW'(1);
                end
            end
        end
    end

    // ---- stage p0 -> p1: RAM write, RAM read into skid slot ----
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_idx] <= i_wr_if.dat;
        if (rd_en) begin
            skid_dat_p1[wr_ptr]  <= mem[idx];
            skid_sop_p1[wr_ptr]  <= (idx == '0);
            skid_eop_p1[wr_ptr]  <= mode_r || (idx == IDX_LAST);
            skid_mode_p1[wr_ptr] <= mode_r;
        end
    end

    // Gating with vld_p1 keeps the payload at zero while idle without resetting data regs.
    assign o_pnt_scl_if.val = vld_p1;
    assign o_pnt_scl_if.dat = vld_p1 ? skid_dat_p1[rd_ptr] : '0;
    assign o_pnt_scl_if.sop = vld_p1 && skid_sop_p1[rd_ptr];
    assign o_pnt_scl_if.eop = vld_p1 && skid_eop_p1[rd_ptr];
    assign o_pnt_scl_if.ctl = CTL_BITS'(vld_p1 && skid_mode_p1[rd_ptr]);

`ifdef MULTIEXP_STREAM_WR_ERR_EN
    assign i_wr_if.rdy = 1'b1;
    assign wr_en       = i_wr_if.val && !o_busy && wr_in_range;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                    o_wr_err <= 1'b0;
        else if (start_acc)              o_wr_err <= 1'b0;
        else if (i_wr_if.val && o_busy)  o_wr_err <= 1'b1;
    end
`else
    assign i_wr_if.rdy = !o_busy;
    assign wr_en       = i_wr_if.val && !o_busy && wr_in_range;
    assign o_wr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_multiexp_pnt_scl_stream.sv
// Randomized bench for multiexp_pnt_scl_stream against a queue-based model of the replay stream.
module tb_multiexp_pnt_scl_stream;
    typedef struct packed { logic [7:0] x; logic [7:0] y; } pnt_t;
    typedef logic [7:0] fe_t;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start4, mode4, busy4, done4, err4;
    logic start1, mode1, busy1, done1, err1;

    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) wr4_if ();
    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) out4_if ();
    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) wr1_if ();
    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(8)) out1_if ();

    multiexp_pnt_scl_stream #(
        .FP_TYPE(pnt_t), .FE_TYPE(fe_t), .KEY_BITS(3), .CTL_BITS(8), .NUM_IN(4)
    ) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_if(wr4_if), .i_start(start4), .i_mode(mode4),
        .o_pnt_scl_if(out4_if), .o_busy(busy4), .o_done(done4), .o_wr_err(err4)
    );

    multiexp_pnt_scl_stream #(
        .FP_TYPE(pnt_t), .FE_TYPE(fe_t), .KEY_BITS(2), .CTL_BITS(8), .NUM_IN(1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_if(wr1_if), .i_start(start1), .i_mode(mode1),
        .o_pnt_scl_if(out1_if), .o_busy(busy1), .o_done(done1), .o_wr_err(err1)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] ram_m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr4(input logic [7:0] idx, input logic [DW-1:0] d);
        wr4_if.val = 1'b1;
        wr4_if.ctl = idx;
        wr4_if.dat = d;
        for (int k = 0; k < 20 && !wr4_if.rdy; k++) @(negedge clk);
        check("wr_rdy_idle", wr4_if.rdy, 1);
        @(negedge clk);
        wr4_if.val = 1'b0;
    endtask

    // Starts a run on the NUM_IN=4/KEY_BITS=3 instance and checks every beat against the model.
    task automatic run4(input bit mode, input int duty, input int abort_at,
                        input bit wr_same, input logic [DW-1:0] wr_same_dat);
        logic [DW-1:0] exp_dat[$];
        bit            exp_sop[$];
        bit            exp_eop[$];
        int            got = 0;
        int            bubbles = 0;
        int            cyc = 0;
        bit            held = 0;
        logic [DW-1:0] h_dat = '0;
        logic          h_sop = 0, h_eop = 0;
        logic [7:0]    h_ctl = '0;

        if (wr_same) ram_m[1] = wr_same_dat;
        if (mode) begin
            exp_dat.push_back(ram_m[0]); exp_sop.push_back(1); exp_eop.push_back(1);
        end else begin
            for (int p = 0; p < 3; p++)
                for (int i = 0; i < 4; i++) begin
                    exp_dat.push_back(ram_m[i]);
                    exp_sop.push_back(i == 0);
                    exp_eop.push_back(i == 3);
                end
        end

        out4_if.rdy = 1'b0;
        start4 = 1'b1;
        mode4  = mode;
        if (wr_same) begin
            wr4_if.val = 1'b1; wr4_if.ctl = 8'd1; wr4_if.dat = wr_same_dat;
        end
        @(negedge clk);
        start4 = 1'b0;
        wr4_if.val = 1'b0;
        check("busy_lat", busy4, 1);
        check("val_lat", out4_if.val, 0);
        check("wr_err_clr", err4, 0);
        @(negedge clk);
        check("val_first", out4_if.val, 1);

        while (got < exp_dat.size() && cyc < 400) begin
            out4_if.rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            if (held) begin
                check("hold_val", out4_if.val, 1);
                check("hold_dat", out4_if.dat, h_dat);
                check("hold_sop", out4_if.sop, h_sop);
                check("hold_eop", out4_if.eop, h_eop);
                check("hold_ctl", out4_if.ctl, h_ctl);
            end
            if (out4_if.val && out4_if.rdy) begin
                check("beat_dat", out4_if.dat, exp_dat[got]);
                check("beat_sop", out4_if.sop, exp_sop[got]);
                check("beat_eop", out4_if.eop, exp_eop[got]);
                check("beat_ctl", out4_if.ctl, {7'd0, mode});
                check("beat_busy", busy4, 1);
                got++;
            end else if (!out4_if.val && got > 0) begin
                bubbles++;
            end
            held  = out4_if.val && !out4_if.rdy;
            h_dat = out4_if.dat; h_sop = out4_if.sop; h_eop = out4_if.eop; h_ctl = out4_if.ctl;
            if (got == exp_dat.size() || got == abort_at) break;
            @(negedge clk);
            cyc++;
        end

        check("beats", got, (abort_at >= 0) ? abort_at : exp_dat.size());
        if (duty >= 100 && abort_at < 0) check("bubbles", bubbles, 0);

        if (abort_at >= 0) begin
            @(negedge clk);
            out4_if.rdy = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("rst_val", out4_if.val, 0);
            check("rst_busy", busy4, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("rst_no_done", done4, 0);
            end
        end else begin
            check("done_pre", done4, 0);
            @(negedge clk);
            check("done", done4, 1);
            check("busy_end", busy4, 0);
            check("val_end", out4_if.val, 0);
            @(negedge clk);
            check("done_pulse", done4, 0);
            out4_if.rdy = 1'b0;
        end
    endtask

    initial begin
        logic [DW-1:0] new_d;
        logic [DW-1:0] d1;
        int            got1;

        rst_n = 1'b0;
        start4 = 0; mode4 = 0; start1 = 0; mode1 = 0;
        wr4_if.val = 0; wr4_if.sop = 0; wr4_if.eop = 0; wr4_if.dat = '0; wr4_if.ctl = '0;
        wr1_if.val = 0; wr1_if.sop = 0; wr1_if.eop = 0; wr1_if.dat = '0; wr1_if.ctl = '0;
        out4_if.rdy = 0; out1_if.rdy = 0;
        repeat (3) @(negedge clk);

        check("rst_val", out4_if.val, 0);
        check("rst_sop", out4_if.sop, 0);
        check("rst_eop", out4_if.eop, 0);
        check("rst_dat", out4_if.dat, 0);
        check("rst_ctl", out4_if.ctl, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_err", err4, 0);
        check("rst_wr_rdy", wr4_if.rdy, 1);
        check("rst_val1", out1_if.val, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            ram_m[i] = {16'($urandom), 8'(i + 1)};
            wr4(8'(i), ram_m[i]);
        end

        run4(0, 100, -1, 0, '0);

        new_d = {16'($urandom), 8'hC2};
        fork
            run4(0, 30, -1, 0, '0);
            begin
                repeat (3) @(negedge clk);
                wr4_if.val = 1'b1; wr4_if.ctl = 8'd2; wr4_if.dat = new_d;
`ifdef MULTIEXP_STREAM_WR_ERR_EN
                check("wr_rdy_busy", wr4_if.rdy, 1);
                @(negedge clk);
                wr4_if.val = 1'b0;
`else
                for (int k = 0; k < 400 && !wr4_if.rdy; k++) begin
                    check("wr_stall_busy", busy4, 1);
                    @(negedge clk);
                end
                check("wr_rdy_after", wr4_if.rdy, 1);
                check("wr_land_done", done4, 1);
                ram_m[2] = new_d;
                @(negedge clk);
                wr4_if.val = 1'b0;
`endif
            end
        join
`ifdef MULTIEXP_STREAM_WR_ERR_EN
        check("wr_err_set", err4, 1);
`else
        check("wr_err_tied", err4, 0);
`endif

        ram_m[0] = {16'($urandom), 8'h05};
        wr4(8'd0, ram_m[0]);
        run4(1, 100, -1, 0, '0);

        run4(0, 30, 5, 0, '0);
        run4(0, 100, -1, 1, {16'($urandom), 8'h9E});

        d1 = {16'($urandom), 8'h3C};
        wr1_if.val = 1'b1; wr1_if.ctl = 8'd0; wr1_if.dat = d1;
        @(negedge clk);
        check("wr1_rdy", wr1_if.rdy, 1);
        wr1_if.ctl = 8'd1; wr1_if.dat = ~d1;
        @(negedge clk);
        wr1_if.val = 1'b0;
        start1 = 1'b1; mode1 = 1'b0; out1_if.rdy = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        got1 = 0;
        for (int c = 0; c < 20; c++) begin
            if (out1_if.val && out1_if.rdy) begin
                check("n1_dat", out1_if.dat, d1);
                check("n1_sop", out1_if.sop, 1);
                check("n1_eop", out1_if.eop, 1);
                got1++;
            end
            if (got1 == 2) break;
            @(negedge clk);
        end
        check("n1_beats", got1, 2);
        @(negedge clk);
        check("n1_done", done1, 1);
        check("n1_val_end", out1_if.val, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
